spram_fifo_ctrl: RTL

Controller that turns the team's 16×8 single-port RAM into a valid/ready FIFO. It sits directly upstream of the RAM: it drives the RAM's `en`/`wr_en`/`address`/`data_in` and consumes its registered `data_out`. Producer and consumer streams share the single RAM port through a round-robin arbiter, giving one RAM operation per cycle.

---
 rtl/spram_fifo_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/spram_fifo_ctrl.sv
// spram_fifo_ctrl
//   Turns a 2^AW x DW single-port RAM with registered read data into a
//   valid/ready FIFO. Producer writes and consumer reads share the one RAM
//   port through a round-robin arbiter, so at most one RAM operation is
//   issued per cycle. The word presented to the consumer lives in the RAM's
//   own output register; rd_valid tracks whether that register holds an
//   unconsumed word.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   wr_valid/wr_data    producer stream in
//   wr_ready            producer word accepted this cycle (combinational)
//   rd_valid/rd_data    consumer stream out (rd_data is the RAM data_out)
//   rd_ready            consumer takes the word
//   level               words held in RAM, not counting the output word
//   full, empty         level == depth; nothing stored and nothing presented
//   ram_en, ram_wr_en, ram_address, ram_data_in   RAM port drive
//   ram_data_out        RAM registered read data
module spram_fifo_ctrl #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          rd_ready,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          ram_en,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data_in,
  input  logic [DW-1:0] ram_data_out
);

  localparam logic [AW:0] LEVEL_FULL = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          rd_valid_q, rd_valid_d;
  logic          last_grant_q, last_grant_d;  // 1 = last grant was a write

  logic wr_req, rd_req, grant_wr, grant_rd;

  assign rd_data = ram_data_out;

  always_comb begin
    full  = (level_q == LEVEL_FULL);
    empty = (level_q == '0) && !rd_valid_q;

    wr_req = wr_valid && !full;
    // A read may be issued only when the output register is free or is
    // being emptied this cycle, so the presented word is never overwritten.
    rd_req = (level_q != '0) && (!rd_valid_q || rd_ready);

    // Under contention the side that did not win last time gets the port.
    grant_wr = rst_n && wr_req && (!rd_req || !last_grant_q);
    grant_rd = rst_n && rd_req && (!wr_req || last_grant_q);

    wr_ready    = grant_wr;
    ram_en      = grant_wr || grant_rd;
    ram_wr_en   = grant_wr;
    ram_address = '0;
    ram_data_in = '0;
    if (grant_wr) begin
      ram_address = wr_ptr_q;
      ram_data_in = wr_data;
    end else if (grant_rd) begin
      ram_address = rd_ptr_q;
    end

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    rd_valid_d   = rd_valid_q;
    last_grant_d = last_grant_q;

    if (grant_wr) begin
      wr_ptr_d     = wr_ptr_q + 1'b1;
      level_d      = level_q + 1'b1;
      last_grant_d = 1'b1;
    end else if (grant_rd) begin
      rd_ptr_d     = rd_ptr_q + 1'b1;
      level_d      = level_q - 1'b1;
      last_grant_d = 1'b0;
    end

    if (grant_rd) begin
      rd_valid_d = 1'b1;
    end else if (rd_ready) begin
      rd_valid_d = 1'b0;
    end

    level    = level_q;
    rd_valid = rd_valid_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      rd_valid_q   <= 1'b0;
      last_grant_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      rd_valid_q   <= rd_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule
